// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// Sizing constants, FSM state encoding and the byte-enable merge.
package dcache_pkg;
   localparam int DCACHE_LINES   = 16;
   localparam int DCACHE_INDEX_W = $clog2(DCACHE_LINES);
   localparam int DCACHE_TAG_W   = 32 - DCACHE_INDEX_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WR_MEM = 2'd1,
      ST_RD_MEM = 2'd2,
      ST_RESP   = 2'd3
   } dcache_state_e;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction
endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one combinational lookup port, one synchronous
// write port, and a synchronous clear of every valid bit on rst.
module dcache_array #(
   parameter int LINES   = 16,
   parameter int INDEX_W = 4,
   parameter int TAG_W   = 28
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] lk_index_i,
   input  logic [TAG_W-1:0]   lk_tag_i,
   output logic               lk_hit_o,
   output logic [31:0]        lk_data_o,
   input  logic               wr_en_i,
   input  logic [INDEX_W-1:0] wr_index_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [31:0]        wr_data_i
);
   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [TAG_W-1:0] tag_d  [LINES];
   logic [31:0]      data_q [LINES];
   logic [31:0]      data_d [LINES];

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (wr_en_i) begin
         valid_d[wr_index_i] = 1'b1;
         tag_d[wr_index_i]   = wr_tag_i;
         data_d[wr_index_i]  = wr_data_i;
      end
      // Only valid bits are cleared; stale tag/data are unreachable afterwards.
      if (rst) valid_d = '0;
   end

   always_ff @(posedge clk) begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
   end

   assign lk_hit_o  = valid_q[lk_index_i] && (tag_q[lk_index_i] == lk_tag_i);
   assign lk_data_o = data_q[lk_index_i];
endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-through data cache sitting between the CPU data port
// and a req/ack backing memory; stalls the CPU while memory is busy.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | accepting CPU requests; read hits answered next cycle
// ST_WR_MEM | write-through to memory in flight
// ST_RD_MEM | line fill from memory in flight
// ST_RESP   | read answer cycle (fill data, or read queued behind a write)
module dcache_dm
   import dcache_pkg::*;
#(
   parameter int LINES = DCACHE_LINES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_raddr_i,
   input  logic [31:0] cpu_waddr_i,
   input  logic [31:0] cpu_wdata_i,
   input  logic        cpu_we_i,
   input  logic        cpu_re_i,
   input  logic [3:0]  cpu_sel_i,
   output logic [31:0] cpu_rdata_o,
   output logic        cpu_rvalid_o,
   output logic        cpu_stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_sel_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i
);
   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = 32 - INDEX_W;

   dcache_state_e state_q, state_d;
   logic [31:0]   rd_addr_q, rd_addr_d;
   logic          rd_pend_q, rd_pend_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]    mem_sel_q, mem_sel_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rvalid_q, rvalid_d;

   logic [31:0]   lk_addr;
   logic          lk_hit;
   logic [31:0]   lk_data;
   logic          wr_en;
   logic [31:0]   wr_data;

   dcache_array #(
      .LINES   (LINES),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .lk_index_i (lk_addr[INDEX_W-1:0]),
      .lk_tag_i   (lk_addr[31:INDEX_W]),
      .lk_hit_o   (lk_hit),
      .lk_data_o  (lk_data),
      .wr_en_i    (wr_en),
      .wr_index_i (lk_addr[INDEX_W-1:0]),
      .wr_tag_i   (lk_addr[31:INDEX_W]),
      .wr_data_i  (wr_data)
   );

   // The single lookup port follows the CPU in IDLE and the latched read otherwise.
   always_comb begin
      lk_addr = rd_addr_q;
      if (state_q == ST_IDLE) lk_addr = cpu_we_i ? cpu_waddr_i : cpu_raddr_i;
   end

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      rd_pend_d   = rd_pend_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_sel_d   = mem_sel_q;
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;
      wr_en       = 1'b0;
      wr_data     = merge_bytes(lk_data, cpu_wdata_i, cpu_sel_i);

      case (state_q)
         ST_IDLE: begin
            if (cpu_we_i) begin
               wr_en       = lk_hit || (cpu_sel_i == 4'hF);
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = cpu_waddr_i;
               mem_wdata_d = cpu_wdata_i;
               mem_sel_d   = cpu_sel_i;
               rd_pend_d   = cpu_re_i;
               rd_addr_d   = cpu_raddr_i;
               state_d     = ST_WR_MEM;
            end else if (cpu_re_i) begin
               rd_pend_d = 1'b0;
               if (lk_hit) begin
                  rdata_d  = lk_data;
                  rvalid_d = 1'b1;
               end else begin
                  rd_addr_d  = cpu_raddr_i;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = cpu_raddr_i;
                  mem_sel_d  = 4'hF;
                  state_d    = ST_RD_MEM;
               end
            end
         end
         ST_WR_MEM: begin
            if (mem_ack_i) begin
               mem_req_d = 1'b0;
               if (!rd_pend_q) begin
                  state_d = ST_IDLE;
               end else if (lk_hit) begin
                  state_d = ST_RESP;
               end else begin
                  rd_pend_d  = 1'b0;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = rd_addr_q;
                  mem_sel_d  = 4'hF;
                  state_d    = ST_RD_MEM;
               end
            end
         end
         ST_RD_MEM: begin
            if (mem_ack_i) begin
               wr_en     = 1'b1;
               wr_data   = mem_rdata_i;
               rdata_d   = mem_rdata_i;
               rvalid_d  = 1'b1;
               mem_req_d = 1'b0;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: begin
            // A read queued behind a write is answered here, one cycle after entry.
            if (rd_pend_q) begin
               rdata_d   = lk_data;
               rvalid_d  = 1'b1;
               rd_pend_d = 1'b0;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rd_addr_q   <= '0;
         rd_pend_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_sel_q   <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         rd_pend_q   <= rd_pend_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_sel_q   <= mem_sel_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
      end
   end

   assign cpu_stall_o  = (state_q != ST_IDLE);
   assign cpu_rdata_o  = rdata_q;
   assign cpu_rvalid_o = rvalid_q;
   assign mem_req_o    = mem_req_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;
   assign mem_sel_o    = mem_sel_q;
endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: directed scenarios plus random traffic against an
// address-keyed cache model and a req/ack memory responder.
module tb_dcache_dm;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cpu_raddr_i = '0, cpu_waddr_i = '0, cpu_wdata_i = '0;
   logic        cpu_we_i = 1'b0, cpu_re_i = 1'b0;
   logic [3:0]  cpu_sel_i = '0;
   logic [31:0] cpu_rdata_o;
   logic        cpu_rvalid_o, cpu_stall_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ack_i = 1'b0;

   dcache_dm #(.LINES(16)) dut (
      .clk(clk), .rst(rst),
      .cpu_raddr_i(cpu_raddr_i), .cpu_waddr_i(cpu_waddr_i), .cpu_wdata_i(cpu_wdata_i),
      .cpu_we_i(cpu_we_i), .cpu_re_i(cpu_re_i), .cpu_sel_i(cpu_sel_i),
      .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_stall_o(cpu_stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
   } txn_t;

   typedef struct {
      int          req_cyc;
      int          first_stall;
      int          first_req;
      int          stall0;
      int          n_rv;
      int          rv_cyc;
      logic [31:0] rv_data;
      int          n_txn;
      txn_t        t0;
      txn_t        t1;
      int          ack0;
      int          ack1;
   } obs_t;

   txn_t txn_q[$];
   int   ack_q[$];
   int   ack_delay = -1;

   // Behavioural model: memory by address, cache lines remembered by full address.
   logic [31:0] mem_model [logic [31:0]];
   logic        ref_valid [16];
   logic [31:0] ref_addr  [16];
   logic [31:0] ref_data  [16];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return 32'h5EED_0000 ^ (a * 32'h0001_0003);
   endfunction

   function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
      logic [31:0] m;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~m) | (n & m);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
   endtask

   task automatic model_access(input bit we, input bit re, input logic [31:0] wa,
                               input logic [31:0] ra, input logic [31:0] wd,
                               input logic [3:0] sel, output bit rd_hit,
                               output logic [31:0] rd_data);
      int wi, ri;
      rd_hit  = 1'b0;
      rd_data = '0;
      if (we) begin
         wi = int'(wa[3:0]);
         if (ref_valid[wi] && ref_addr[wi] == wa) ref_data[wi] = tb_merge(ref_data[wi], wd, sel);
         else if (sel == 4'hF) begin
            ref_valid[wi] = 1'b1; ref_addr[wi] = wa; ref_data[wi] = wd;
         end
         mem_model[wa] = tb_merge(mem_rd(wa), wd, sel);
      end
      if (re) begin
         ri = int'(ra[3:0]);
         rd_hit = ref_valid[ri] && ref_addr[ri] == ra;
         if (rd_hit) rd_data = ref_data[ri];
         else begin
            rd_data = mem_rd(ra);
            ref_valid[ri] = 1'b1; ref_addr[ri] = ra; ref_data[ri] = rd_data;
         end
      end
   endtask

   // Memory responder: acks after ack_delay req cycles (random 0..3 when negative).
   initial begin
      int   cnt;
      txn_t snap, cur;
      cnt = -1;
      forever begin
         @(negedge clk);
         mem_ack_i = 1'b0;
         cur = '{we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o, sel: mem_sel_o};
         if (mem_req_o && !rst) begin
            if (cnt < 0) begin
               cnt  = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
               snap = cur;
            end else begin
               n_cmp++;
               if (cur !== snap) begin
                  n_err++;
                  $display("FAIL mem_stable: got %h required %h", cur, snap);
               end
            end
            if (cnt == 0) begin
               mem_ack_i   = 1'b1;
               mem_rdata_i = mem_we_o ? $urandom : mem_rd(mem_addr_o);
               txn_q.push_back(cur);
               ack_q.push_back(cyc);
               cnt = -1;
            end else cnt--;
         end else cnt = -1;
      end
   end

   task automatic do_req(input bit we, input bit re, input logic [31:0] wa,
                         input logic [31:0] ra, input logic [31:0] wd,
                         input logic [3:0] sel, output obs_t o);
      int guard;
      o = '{req_cyc: 0, first_stall: -1, first_req: -1, stall0: -1, n_rv: 0, rv_cyc: -1,
            rv_data: '0, n_txn: 0, t0: '0, t1: '0, ack0: -100, ack1: -100};
      txn_q.delete();
      ack_q.delete();
      @(negedge clk);
      cpu_we_i = we; cpu_re_i = re; cpu_waddr_i = wa; cpu_raddr_i = ra;
      cpu_wdata_i = wd; cpu_sel_i = sel;
      o.req_cyc = cyc;
      guard = 0;
      while (1) begin
         @(posedge clk); #1;
         cpu_we_i = 1'b0; cpu_re_i = 1'b0;
         if (cpu_stall_o && o.first_stall < 0) o.first_stall = cyc;
         if (mem_req_o && o.first_req < 0) o.first_req = cyc;
         if (cpu_rvalid_o) begin
            o.n_rv++; o.rv_cyc = cyc; o.rv_data = cpu_rdata_o;
         end
         if (!cpu_stall_o) begin
            o.stall0 = cyc;
            break;
         end
         guard++;
         if (guard > 60) break;
      end
      n_cmp++;
      if (guard > 60) begin
         n_err++;
         $display("FAIL timeout: stall still %0d after %0d cycles, required 0", cpu_stall_o, guard);
      end
      @(posedge clk); #1;
      if (cpu_rvalid_o) o.n_rv++;
      o.n_txn = txn_q.size();
      if (txn_q.size() > 0) begin o.t0 = txn_q[0]; o.ack0 = ack_q[0]; end
      if (txn_q.size() > 1) begin o.t1 = txn_q[1]; o.ack1 = ack_q[1]; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({cpu_rdata_o, cpu_rvalid_o, cpu_stall_o} !== 34'h0) begin
         n_err++;
         $display("FAIL reset_cpu: got rdata=%h rvalid=%b stall=%b required 0", cpu_rdata_o, cpu_rvalid_o, cpu_stall_o);
      end
      n_cmp++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o} !== 70'h0) begin
         n_err++;
         $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h sel=%h required 0",
                  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_write_read();
      obs_t o; bit h; logic [31:0] d;
      model_access(1, 0, 32'd3, 32'd0, 32'h1234, 4'hF, h, d);
      do_req(1, 0, 32'd3, 32'd0, 32'h1234, 4'hF, o);
      n_cmp++;
      if (o.n_txn !== 1 || o.t0.we !== 1'b1 || o.t0.addr !== 32'd3 || o.t0.wdata !== 32'h1234) begin
         n_err++;
         $display("FAIL wr_txn: got n=%0d txn=%h required one write addr 3 data 1234", o.n_txn, o.t0);
      end
      n_cmp++;
      if (o.first_stall != o.req_cyc + 1 || o.stall0 != o.ack0 + 1) begin
         n_err++;
         $display("FAIL wr_stall: got rise %0d drop %0d required %0d %0d",
                  o.first_stall, o.stall0, o.req_cyc + 1, o.ack0 + 1);
      end
      model_access(0, 1, 32'd0, 32'd3, 32'd0, 4'hF, h, d);
      do_req(0, 1, 32'd0, 32'd3, 32'd0, 4'hF, o);
      n_cmp++;
      if (o.n_txn != 0 || o.n_rv != 1 || o.rv_cyc != o.req_cyc + 1 || o.rv_data !== 32'h1234) begin
         n_err++;
         $display("FAIL rd_hit3: got n=%0d rv=%0d@%0d data=%h required 0 1@%0d 00001234",
                  o.n_txn, o.n_rv, o.rv_cyc, o.rv_data, o.req_cyc + 1);
      end
   endtask

   task automatic test_cold_read();
      obs_t o; bit h; logic [31:0] d;
      mem_model[32'd5] = 32'hBEEF;
      ack_delay = 3;
      model_access(0, 1, 32'd0, 32'd5, 32'd0, 4'hF, h, d);
      do_req(0, 1, 32'd0, 32'd5, 32'd0, 4'hF, o);
      ack_delay = -1;
      n_cmp++;
      if (o.n_txn != 1 || o.t0.we !== 1'b0 || o.t0.addr !== 32'd5 || o.t0.sel !== 4'hF ||
          o.ack0 != o.req_cyc + 4) begin
         n_err++;
         $display("FAIL cold_txn: got n=%0d txn=%h ack@%0d required read addr 5 sel f ack@%0d",
                  o.n_txn, o.t0, o.ack0, o.req_cyc + 4);
      end
      n_cmp++;
      if (o.rv_data !== 32'hBEEF || o.n_rv != 1 || o.rv_cyc != o.ack0 + 1 || o.stall0 != o.ack0 + 2) begin
         n_err++;
         $display("FAIL cold_resp: got data=%h rv=%0d@%0d drop=%0d required 0000beef 1@%0d %0d",
                  o.rv_data, o.n_rv, o.rv_cyc, o.stall0, o.ack0 + 1, o.ack0 + 2);
      end
      model_access(0, 1, 32'd0, 32'd5, 32'd0, 4'hF, h, d);
      do_req(0, 1, 32'd0, 32'd5, 32'd0, 4'hF, o);
      n_cmp++;
      if (o.n_txn != 0 || o.rv_data !== 32'hBEEF || o.first_stall != -1) begin
         n_err++;
         $display("FAIL cold_rehit: got n=%0d data=%h stall@%0d required 0 0000beef none",
                  o.n_txn, o.rv_data, o.first_stall);
      end
   endtask

   task automatic test_conflict();
      obs_t o; bit h; logic [31:0] d; logic [31:0] a;
      for (int k = 0; k < 3; k++) begin
         a = (k == 1) ? 32'h12 : 32'h02;
         model_access(0, 1, 32'd0, a, 32'd0, 4'hF, h, d);
         do_req(0, 1, 32'd0, a, 32'd0, 4'hF, o);
         n_cmp++;
         if (o.n_txn != 1 || o.t0.addr !== a || o.t0.we !== 1'b0 || o.rv_data !== mem_rd(a)) begin
            n_err++;
            $display("FAIL conflict_%0d: got n=%0d addr=%h data=%h required 1 %h %h",
                     k, o.n_txn, o.t0.addr, o.rv_data, a, mem_rd(a));
         end
      end
   endtask

   task automatic test_partial();
      obs_t o; bit h; logic [31:0] d;
      model_access(1, 0, 32'h21, 32'd0, 32'h11223344, 4'hF, h, d);
      do_req(1, 0, 32'h21, 32'd0, 32'h11223344, 4'hF, o);
      model_access(1, 0, 32'h21, 32'd0, 32'hAAAA5555, 4'b0011, h, d);
      do_req(1, 0, 32'h21, 32'd0, 32'hAAAA5555, 4'b0011, o);
      n_cmp++;
      if (o.n_txn != 1 || o.t0.sel !== 4'b0011 || o.t0.wdata !== 32'hAAAA5555) begin
         n_err++;
         $display("FAIL part_txn: got n=%0d sel=%b wdata=%h required 1 0011 aaaa5555", o.n_txn, o.t0.sel, o.t0.wdata);
      end
      model_access(0, 1, 32'd0, 32'h21, 32'd0, 4'hF, h, d);
      do_req(0, 1, 32'd0, 32'h21, 32'd0, 4'hF, o);
      n_cmp++;
      if (o.n_txn != 0 || o.rv_data !== 32'h11225555) begin
         n_err++;
         $display("FAIL part_hit: got n=%0d data=%h required 0 11225555", o.n_txn, o.rv_data);
      end
      model_access(1, 0, 32'd9, 32'd0, 32'h00005A5A, 4'b0011, h, d);
      do_req(1, 0, 32'd9, 32'd0, 32'h00005A5A, 4'b0011, o);
      model_access(0, 1, 32'd0, 32'd9, 32'd0, 4'hF, h, d);
      do_req(0, 1, 32'd0, 32'd9, 32'd0, 4'hF, o);
      n_cmp++;
      if (o.n_txn != 1 || o.t0.addr !== 32'd9 || o.rv_data !== d) begin
         n_err++;
         $display("FAIL part_miss: got n=%0d addr=%h data=%h required 1 00000009 %h", o.n_txn, o.t0.addr, o.rv_data, d);
      end
   endtask

   task automatic test_we_re();
      obs_t o; bit h; logic [31:0] d;
      model_access(1, 1, 32'd7, 32'd7, 32'h77, 4'hF, h, d);
      do_req(1, 1, 32'd7, 32'd7, 32'h77, 4'hF, o);
      n_cmp++;
      if (o.n_txn != 1 || o.t0.we !== 1'b1 || o.t0.addr !== 32'd7) begin
         n_err++;
         $display("FAIL were_txn: got n=%0d txn=%h required one write addr 7", o.n_txn, o.t0);
      end
      n_cmp++;
      if (o.n_rv != 1 || o.rv_cyc != o.ack0 + 2 || o.rv_data !== 32'h77 || o.stall0 != o.ack0 + 2) begin
         n_err++;
         $display("FAIL were_resp: got rv=%0d@%0d data=%h drop=%0d required 1@%0d 00000077 %0d",
                  o.n_rv, o.rv_cyc, o.rv_data, o.stall0, o.ack0 + 2, o.ack0 + 2);
      end
   endtask

   task automatic test_reset_mid();
      obs_t o; bit h; logic [31:0] d; int bad;
      model_access(0, 1, 32'd0, 32'h44, 32'd0, 4'hF, h, d);
      do_req(0, 1, 32'd0, 32'h44, 32'd0, 4'hF, o);
      model_access(0, 1, 32'd0, 32'h44, 32'd0, 4'hF, h, d);
      do_req(0, 1, 32'd0, 32'h44, 32'd0, 4'hF, o);
      n_cmp++;
      if (o.n_txn != 0) begin
         n_err++;
         $display("FAIL rstmid_prehit: got %0d mem txns required 0", o.n_txn);
      end
      ack_delay = 1000;
      @(negedge clk);
      cpu_re_i = 1'b1; cpu_raddr_i = 32'h56;
      @(posedge clk); #1;
      cpu_re_i = 1'b0;
      n_cmp++;
      if (mem_req_o !== 1'b1 || cpu_stall_o !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_wait: got req=%b stall=%b required 1 1", mem_req_o, cpu_stall_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++;
      if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0 || cpu_rvalid_o !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_drop: got req=%b stall=%b rvalid=%b required 0 0 0", mem_req_o, cpu_stall_o, cpu_rvalid_o);
      end
      bad = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (cpu_rvalid_o || mem_req_o || cpu_stall_o) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL rstmid_quiet: got %0d busy cycles required 0", bad);
      end
      ack_delay = -1;
      model_reset();
      model_access(0, 1, 32'd0, 32'h44, 32'd0, 4'hF, h, d);
      do_req(0, 1, 32'd0, 32'h44, 32'd0, 4'hF, o);
      n_cmp++;
      if (o.n_txn != 1 || o.t0.addr !== 32'h44 || o.rv_data !== d) begin
         n_err++;
         $display("FAIL rstmid_miss: got n=%0d addr=%h data=%h required 1 00000044 %h", o.n_txn, o.t0.addr, o.rv_data, d);
      end
   endtask

   task automatic test_random();
      obs_t o; bit we, re, rh; logic [31:0] wa, ra, wd, ed; logic [3:0] sel;
      int nt, erv, es0, kind;
      for (int k = 0; k < 150; k++) begin
         kind = int'($urandom_range(0, 3));
         we = (kind == 1) || (kind == 2);
         re = (kind != 1);
         wa = $urandom_range(0, 47);
         ra = ($urandom_range(0, 3) == 0) ? wa : 32'($urandom_range(0, 47));
         wd = $urandom;
         sel = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         model_access(we, re, wa, ra, wd, sel, rh, ed);
         do_req(we, re, wa, ra, wd, sel, o);
         nt = (we ? 1 : 0) + ((re && !rh) ? 1 : 0);
         erv = -1;
         if (!we) begin
            erv = rh ? o.req_cyc + 1 : o.ack0 + 1;
            es0 = rh ? o.req_cyc + 1 : o.ack0 + 2;
         end else if (!re) es0 = o.ack0 + 1;
         else if (rh) begin erv = o.ack0 + 2; es0 = o.ack0 + 2; end
         else begin erv = o.ack1 + 1; es0 = o.ack1 + 2; end
         n_cmp++;
         if (o.n_txn != nt || o.n_rv != (re ? 1 : 0)) begin
            n_err++;
            $display("FAIL rnd%0d_count: got txns=%0d rv=%0d required %0d %0d", k, o.n_txn, o.n_rv, nt, re ? 1 : 0);
         end
         n_cmp++;
         if (o.stall0 != es0 || o.rv_cyc != erv || o.first_req != ((nt > 0) ? o.req_cyc + 1 : -1)) begin
            n_err++;
            $display("FAIL rnd%0d_timing: got drop=%0d rv@%0d req@%0d required %0d %0d %0d", k,
                     o.stall0, o.rv_cyc, o.first_req, es0, erv, (nt > 0) ? o.req_cyc + 1 : -1);
         end
         if (re) begin
            n_cmp++;
            if (o.rv_data !== ed) begin
               n_err++;
               $display("FAIL rnd%0d_data: got %h required %h", k, o.rv_data, ed);
            end
         end
         if (nt > 0) begin
            n_cmp++;
            if (we ? (o.t0 !== {1'b1, wa, wd, sel}) : (o.t0.we !== 1'b0 || o.t0.addr !== ra || o.t0.sel !== 4'hF)) begin
               n_err++;
               $display("FAIL rnd%0d_txn0: got %h required we=%b addr=%h", k, o.t0, we, we ? wa : ra);
            end
         end
         if (nt > 1) begin
            n_cmp++;
            if (o.t1.we !== 1'b0 || o.t1.addr !== ra || o.t1.sel !== 4'hF) begin
               n_err++;
               $display("FAIL rnd%0d_txn1: got %h required read addr %h", k, o.t1, ra);
            end
         end
      end
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_cold_read();
      test_conflict();
      test_partial();
      test_we_re();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
